// File: rtl/mem_pkg.sv
// Purpose: shared types and widths for the 32-bit word to 16-bit SDRAM path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_DATA_W = 16;
  localparam int WORD_W       = 32;

  typedef enum logic [2:0] {
    IDLE,
    LO_ISSUE,
    LO_WAIT,
    HI_ISSUE,
    HI_WAIT,
    DONE
  } bridge_state_t;

endpackage

// File: rtl/sdram_watchdog.sv
// Purpose: per-half-access hang detector; counts cycles while en, cleared by clr.
// Latency: expired is combinational and rises in the TIMEOUT_CYCLES-th enabled cycle.
// Backpressure: none; the owner decides what to do when expired is seen.
// Ports: clk, rst_l (async active-low), clr (restart count), en (waiting cycle),
//        expired (this waiting cycle is the last one allowed).
module sdram_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Count holds the number of enabled cycles already completed, so the
  // current cycle is the last one when the count equals TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/sdram_word_bridge.sv
// Purpose: splits one 32-bit word access into low-then-high 16-bit SDRAM accesses.
// Latency: accept edge to req_done is 5 cycles with SDRAM_done 1 cycle after each
//          SDRAM_as; every extra SDRAM wait or not-ready cycle adds 1.
// Backpressure: req_ready drops while a word is in flight or the PLL is unlocked;
//               SDRAM_as is held off while SDRAM_ready is low.
// Ports: req_* is the 32-bit word side (strobe/rw/addr/wdata in, ready/rdata/done/error out);
//        SDRAM_* is the 16-bit controller side (as/rw/addr/wdata out, ready/done/rdata/pll in).
module sdram_word_bridge
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    req_as,
  input  logic                    req_rw,
  input  logic [SDRAM_ADDR_W-2:0] req_addr,
  input  logic [WORD_W-1:0]       req_data_write,
  output logic                    req_ready,
  output logic [WORD_W-1:0]       req_data_read,
  output logic                    req_done,
  output logic                    req_error,
  input  logic                    SDRAM_pll_locked,
  input  logic                    SDRAM_ready,
  output logic                    SDRAM_as,
  output logic                    SDRAM_rw,
  output logic [SDRAM_ADDR_W-1:0] SDRAM_addr,
  output logic [SDRAM_DATA_W-1:0] SDRAM_data_write,
  input  logic [SDRAM_DATA_W-1:0] SDRAM_data_read,
  input  logic                    SDRAM_done
);

  bridge_state_t           state;
  logic                    accept;
  logic                    issue;
  logic                    wd_en;
  logic                    wd_expired;
  logic                    rw_q;
  logic [SDRAM_ADDR_W-1:0] sd_addr_q;
  logic [SDRAM_DATA_W-1:0] sd_wdata_q;
  logic [SDRAM_DATA_W-1:0] wdata_hi_q;
  logic [SDRAM_DATA_W-1:0] rd_lo_q;
  logic [SDRAM_DATA_W-1:0] rd_hi_q;

  assign req_ready = (state == IDLE) && SDRAM_pll_locked;
  assign accept    = req_as && req_ready;
  // The strobe must follow SDRAM_ready in the same cycle, so it is decoded
  // from the registered state rather than registered itself.
  assign issue     = ((state == LO_ISSUE) || (state == HI_ISSUE)) && SDRAM_ready;
  assign wd_en     = (state == LO_WAIT) || (state == HI_WAIT);

  assign SDRAM_as         = issue;
  assign SDRAM_rw         = rw_q;
  assign SDRAM_addr       = sd_addr_q;
  assign SDRAM_data_write = sd_wdata_q;

  sdram_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_l  (rst_l),
    .clr    (issue || accept),
    .en     (wd_en),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state         <= IDLE;
      rw_q          <= 1'b0;
      sd_addr_q     <= '0;
      sd_wdata_q    <= '0;
      wdata_hi_q    <= '0;
      rd_lo_q       <= '0;
      rd_hi_q       <= '0;
      req_data_read <= '0;
      req_done      <= 1'b0;
      req_error     <= 1'b0;
    end else begin
      req_done  <= 1'b0;
      req_error <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rw_q       <= req_rw;
            sd_addr_q  <= {req_addr, 1'b0};
            sd_wdata_q <= req_data_write[SDRAM_DATA_W-1:0];
            wdata_hi_q <= req_data_write[WORD_W-1:SDRAM_DATA_W];
            state      <= LO_ISSUE;
          end
        end
        LO_ISSUE: begin
          if (SDRAM_ready) state <= LO_WAIT;
        end
        LO_WAIT: begin
          // A completion in the limit cycle takes priority over the abort.
          if (SDRAM_done) begin
            if (rw_q) rd_lo_q <= SDRAM_data_read;
            sd_addr_q[0] <= 1'b1;
            sd_wdata_q   <= wdata_hi_q;
            state        <= HI_ISSUE;
          end else if (wd_expired) begin
            req_done      <= 1'b1;
            req_error     <= 1'b1;
            req_data_read <= '0;
            state         <= IDLE;
          end
        end
        HI_ISSUE: begin
          if (SDRAM_ready) state <= HI_WAIT;
        end
        HI_WAIT: begin
          if (SDRAM_done) begin
            if (rw_q) rd_hi_q <= SDRAM_data_read;
            state <= DONE;
          end else if (wd_expired) begin
            req_done      <= 1'b1;
            req_error     <= 1'b1;
            req_data_read <= '0;
            state         <= IDLE;
          end
        end
        DONE: begin
          req_done <= 1'b1;
          if (rw_q) req_data_read <= {rd_hi_q, rd_lo_q};
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_word_bridge.sv
module tb_sdram_word_bridge;

  typedef struct {
    bit          rw;
    logic [22:0] addr;
    logic [15:0] wd;
  } cmd_t;

  typedef struct {
    bit          err;
    logic [31:0] rd;
    int          lat;
    int          acc;
  } done_t;

  typedef struct {
    int          w;
    logic [15:0] d;
    bit          hang;
  } resp_t;

  logic        clk;
  logic        rst_l;
  logic        req_as;
  logic        req_rw;
  logic [21:0] req_addr;
  logic [31:0] req_data_write;
  logic        req_ready;
  logic [31:0] req_data_read;
  logic        req_done;
  logic        req_error;
  logic        SDRAM_pll_locked;
  logic        SDRAM_ready;
  logic        SDRAM_as;
  logic        SDRAM_rw;
  logic [22:0] SDRAM_addr;
  logic [15:0] SDRAM_data_write;
  logic [15:0] SDRAM_data_read;
  logic        SDRAM_done;

  int checks;
  int failures;
  int cyc;
  int spur_req;
  int spur_ack;

  cmd_t  exp_cmd_q[$];
  done_t exp_done_q[$];
  resp_t resp_q[$];

  sdram_word_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .rst_l           (rst_l),
    .req_as          (req_as),
    .req_rw          (req_rw),
    .req_addr        (req_addr),
    .req_data_write  (req_data_write),
    .req_ready       (req_ready),
    .req_data_read   (req_data_read),
    .req_done        (req_done),
    .req_error       (req_error),
    .SDRAM_pll_locked(SDRAM_pll_locked),
    .SDRAM_ready     (SDRAM_ready),
    .SDRAM_as        (SDRAM_as),
    .SDRAM_rw        (SDRAM_rw),
    .SDRAM_addr      (SDRAM_addr),
    .SDRAM_data_write(SDRAM_data_write),
    .SDRAM_data_read (SDRAM_data_read),
    .SDRAM_done      (SDRAM_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout actual=still_running required=finished");
    $fatal(1, "simulation time bound reached");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a command or a completion.
  initial begin : monitor
    cmd_t  c;
    done_t d;
    forever begin
      @(negedge clk);
      if (SDRAM_as === 1'b1) begin
        if (exp_cmd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_sdram_as actual=addr_%h required=no_command", SDRAM_addr);
        end else begin
          c = exp_cmd_q.pop_front();
          chk("cmd_rw", 32'(SDRAM_rw), 32'(c.rw));
          chk("cmd_addr", 32'(SDRAM_addr), 32'(c.addr));
          chk("cmd_wdata", 32'(SDRAM_data_write), 32'(c.wd));
        end
      end
      if (req_done === 1'b1) begin
        if (exp_done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req_done actual=1 required=0");
        end else begin
          d = exp_done_q.pop_front();
          chk("done_error", 32'(req_error), 32'(d.err));
          chk("done_rdata", req_data_read, d.rd);
          chk("done_latency", 32'(cyc - d.acc), 32'(d.lat));
        end
      end else if (rst_l === 1'b1) begin
        chk("error_without_done", 32'(req_error), 32'd0);
      end
    end
  end

  // Controller model: answers each SDRAM_as from resp_q, plus injected spurious dones.
  initial begin : sdram_model
    int          countdown;
    logic [15:0] rdat;
    resp_t       r;
    countdown       = 0;
    rdat            = '0;
    SDRAM_done      = 1'b0;
    SDRAM_data_read = '0;
    forever begin
      @(negedge clk);
      if (rst_l === 1'b0) begin
        countdown = 0;
      end else if (SDRAM_as === 1'b1 && resp_q.size() > 0) begin
        r         = resp_q.pop_front();
        countdown = r.hang ? 0 : r.w;
        rdat      = r.d;
      end
      @(posedge clk);
      #1;
      SDRAM_done      = 1'b0;
      SDRAM_data_read = 16'h0000;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          SDRAM_done      = 1'b1;
          SDRAM_data_read = rdat;
        end
      end else if (spur_req != spur_ack) begin
        SDRAM_done      = 1'b1;
        SDRAM_data_read = 16'hA5A5;
        spur_ack++;
      end
    end
  end

  task automatic push_resp(input int w, input logic [15:0] d, input bit hang);
    resp_t r;
    r.w = w;
    r.d = d;
    r.hang = hang;
    resp_q.push_back(r);
  endtask

  // Called at posedge+1; returns at posedge+1 of the accept cycle.
  task automatic issue(input bit rw, input logic [21:0] a, input logic [31:0] wd,
                       input bit want_done, input bit err, input logic [31:0] rd, input int lat);
    cmd_t  c;
    done_t d;
    c.rw = rw; c.addr = {a, 1'b0}; c.wd = wd[15:0];
    exp_cmd_q.push_back(c);
    c.addr = {a, 1'b1}; c.wd = wd[31:16];
    exp_cmd_q.push_back(c);
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    req_as = 1'b1; req_rw = rw; req_addr = a; req_data_write = wd;
    @(posedge clk);
    #1;
    req_as = 1'b0;
    if (want_done) begin
      d.err = err; d.rd = rd; d.lat = lat; d.acc = cyc;
      exp_done_q.push_back(d);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((exp_cmd_q.size() > 0 || exp_done_q.size() > 0 || resp_q.size() > 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL %s_timeout actual=pending_cmd_%0d_done_%0d required=0", nm,
               exp_cmd_q.size(), exp_done_q.size());
      exp_cmd_q.delete();
      exp_done_q.delete();
      resp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    checks = 0; failures = 0; cyc = 0; spur_req = 0; spur_ack = 0;
    rst_l = 1'b0; SDRAM_pll_locked = 1'b0; SDRAM_ready = 1'b1;
    req_as = 1'b0; req_rw = 1'b0; req_addr = '0; req_data_write = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_req_done", 32'(req_done), 32'd0);
    chk("rst_req_error", 32'(req_error), 32'd0);
    chk("rst_req_data_read", req_data_read, 32'd0);
    chk("rst_sdram_as", 32'(SDRAM_as), 32'd0);
    chk("rst_sdram_rw", 32'(SDRAM_rw), 32'd0);
    chk("rst_sdram_addr", 32'(SDRAM_addr), 32'd0);
    chk("rst_sdram_wdata", 32'(SDRAM_data_write), 32'd0);
    @(posedge clk); #1;
    rst_l = 1'b1;

    // Strobe while PLL unlocked: must be dropped (monitor flags any SDRAM_as).
    req_as = 1'b1; req_rw = 1'b0; req_addr = 22'h000055; req_data_write = 32'h5555_5555;
    @(negedge clk);
    chk("not_ready_pll_unlocked", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    req_as = 1'b0;
    SDRAM_pll_locked = 1'b1;
    @(negedge clk);
    chk("ready_after_pll_lock", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Write, 1-cycle controller turnaround.
    push_resp(1, 16'h0000, 1'b0); push_resp(1, 16'h0000, 1'b0);
    issue(1'b0, 22'h00000A, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0000, 5);
    wait_idle("write_basic");

    // Read at top address, 3-cycle turnaround per half.
    push_resp(3, 16'h5678, 1'b0); push_resp(3, 16'h1234, 1'b0);
    issue(1'b1, 22'h3FFFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h1234_5678, 9);
    wait_idle("read_top_addr");

    // Spurious done while idle.
    @(negedge clk);
    spur_req++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ready_after_spurious_done", 32'(req_ready), 32'd1);
    end
    @(posedge clk); #1;

    // SDRAM_ready low for 4 cycles in LO_ISSUE; write keeps previous read word.
    SDRAM_ready = 1'b0;
    push_resp(1, 16'h0000, 1'b0); push_resp(1, 16'h0000, 1'b0);
    issue(1'b0, 22'h2AAAAA, 32'h0123_4567, 1'b1, 1'b0, 32'h1234_5678, 9);
    @(negedge clk);
    spur_req++;
    chk("no_as_while_not_ready", 32'(SDRAM_as), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_as_while_not_ready", 32'(SDRAM_as), 32'd0);
    end
    @(posedge clk); #1;
    SDRAM_ready = 1'b1;
    wait_idle("ready_low");

    // High-half done lands in the limit cycle: completion wins.
    push_resp(1, 16'h0BAD, 1'b0); push_resp(8, 16'h0F0F, 1'b0);
    issue(1'b1, 22'h000001, 32'h0000_0000, 1'b1, 1'b0, 32'h0F0F_0BAD, 12);
    wait_idle("done_at_limit");

    // High half never completes: timeout after 8 HI_WAIT cycles.
    push_resp(1, 16'h7777, 1'b0); push_resp(0, 16'h0000, 1'b1);
    issue(1'b1, 22'h123456, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 11);
    wait_idle("timeout");
    @(negedge clk);
    chk("ready_after_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Reset during HI_WAIT; a late done after release must be ignored.
    push_resp(1, 16'h0000, 1'b0); push_resp(0, 16'h0000, 1'b1);
    issue(1'b0, 22'h0ABCDE, 32'h1111_2222, 1'b0, 1'b0, 32'h0, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_l = 1'b0;
    @(negedge clk);
    chk("midrst_req_done", 32'(req_done), 32'd0);
    chk("midrst_sdram_addr", 32'(SDRAM_addr), 32'd0);
    chk("midrst_req_data_read", req_data_read, 32'd0);
    @(posedge clk); #1;
    rst_l = 1'b1;
    @(negedge clk);
    spur_req++;
    chk("ready_after_midrst", 32'(req_ready), 32'd1);
    chk("midrst_cmds_consumed", 32'(exp_cmd_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ready_after_late_done", 32'(req_ready), 32'd1);
    end
    @(posedge clk); #1;

    push_resp(1, 16'hCAFE, 1'b0); push_resp(1, 16'hF00D, 1'b0);
    issue(1'b1, 22'h000ABC, 32'h0000_0000, 1'b1, 1'b0, 32'hF00D_CAFE, 5);
    wait_idle("after_midrst");

    chk("end_cmd_queue_empty", 32'(exp_cmd_q.size()), 32'd0);
    chk("end_done_queue_empty", 32'(exp_done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_word_bridge.md
Name: sdram_word_bridge

Overview:
- Sits directly downstream of mport_manager's SDRAM port and drives the 16-bit SDRAM controller.
- Converts one 32-bit word request into two sequential 16-bit SDRAM accesses: low half first, then high half.
- Returns the assembled 32-bit read word or a write completion as a single-cycle done pulse.
- A per-half watchdog aborts hung accesses and reports an error instead of stalling the memory path.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles spent waiting for SDRAM_done per half-access before abort; must be ≥ 2.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): watchdog counter width (derived, not overridden).

Ports:
- clk  input  1  system clock.
- rst_l  input  1  asynchronous active-low reset; all flops clear immediately on assertion.
- req_as  input  1  word request strobe, sampled only while req_ready=1.
- req_rw  input  1  1=read, 0=write.
- req_addr  input  22  word address.
- req_data_write  input  32  write word.
- req_ready  output  1  bridge idle and SDRAM_pll_locked=1.
- req_data_read  output  32  assembled read word; valid with req_done, held until next accept.
- req_done  output  1  one-cycle completion pulse.
- req_error  output  1  qualifies req_done: 1 = timed out.
- SDRAM_pll_locked  input  1  SDRAM PLL lock.
- SDRAM_ready  input  1  controller can take a command.
- SDRAM_as  output  1  one-cycle command strobe.
- SDRAM_rw  output  1  1=read, 0=write.
- SDRAM_addr  output  23  halfword address.
- SDRAM_data_write  output  16  write halfword.
- SDRAM_data_read  input  16  read halfword, valid with SDRAM_done.
- SDRAM_done  input  1  one-cycle completion from the controller.

Behaviour:
- Reset values:
  - state=IDLE.
  - All outputs 0, including req_data_read=0, req_done=0, req_error=0, SDRAM_as=0, SDRAM_addr=0.
- Clock and reset:
  - One clock domain.
  - rst_l asserted mid-transaction returns the block to IDLE immediately.
  - No req_done is issued for the aborted request.
  - An in-flight SDRAM_done arriving after reset release is ignored because the block is in IDLE.
- req_ready = (state==IDLE) && SDRAM_pll_locked.
  - If req_as is high while req_ready=0, the request is ignored and not queued.
- Accept (IDLE, req_as && req_ready):
  - Latch req_addr, req_rw and req_data_write.
  - Clear the watchdog.
  - Next state LO_ISSUE.
- LO_ISSUE:
  - While SDRAM_ready=1: drive SDRAM_as=1 for exactly 1 cycle with SDRAM_addr={addr,1'b0}, SDRAM_rw=rw, SDRAM_data_write=wdata[15:0].
  - Next state LO_WAIT.
  - While SDRAM_ready=0: hold in LO_ISSUE, SDRAM_as=0.
- LO_WAIT:
  - On SDRAM_done: capture SDRAM_data_read into rdata[15:0] (reads only), then go to HI_ISSUE.
- HI_ISSUE / HI_WAIT: identical to the low half, with these differences:
  - SDRAM_addr={addr,1'b1}.
  - SDRAM_data_write=wdata[31:16].
  - Read data is captured into rdata[31:16].
  - Completion goes to DONE.
- DONE:
  - req_done=1 and req_error=0 for one cycle.
  - req_data_read shows the assembled word on reads; unchanged on writes.
  - Next state IDLE.
- SDRAM_addr, SDRAM_rw and SDRAM_data_write stay stable from issue until the matching SDRAM_done.
- SDRAM_done while in IDLE or either ISSUE state is spurious and ignored.
- Watchdog:
  - Counts every cycle spent in LO_WAIT or HI_WAIT; resets on each issue.
  - If the count reaches TIMEOUT_CYCLES without SDRAM_done: pulse req_done=1 and req_error=1, set req_data_read=0, return to IDLE.
  - SDRAM_done arriving in the same cycle the limit is reached wins; the access completes normally.
- Latency:
  - With SDRAM_ready=1 and SDRAM_done arriving 1 cycle after SDRAM_as, req_done asserts 5 cycles after the accept edge.
  - Each additional SDRAM wait cycle adds 1 cycle.
- Loss of SDRAM_pll_locked mid-transaction does not abort the transaction; the watchdog covers a hang.
- req_error is meaningful only while req_done=1; it is 0 otherwise.

Decomposition:
- Shared package mem_pkg:
  - typedef enum logic [2:0] bridge_state_t {IDLE, LO_ISSUE, LO_WAIT, HI_ISSUE, HI_WAIT, DONE}.
  - localparams SDRAM_ADDR_W=23, SDRAM_DATA_W=16, WORD_W=32.
- Sub-module sdram_watchdog:
  - Clear/enable counter with an expired output, parameterised by TIMEOUT_CYCLES.
- FSM, address/data muxing and read-data assembly stay in sdram_word_bridge.

Test Plan:
- Reset → all outputs 0. Then SDRAM_pll_locked=1 → req_ready=1.
- Write req_addr=22'h00A, data 32'hDEAD_BEEF, controller done 1 cycle after as → SDRAM_as pulses at addr 23'h014 with data 16'hBEEF, then at addr 23'h015 with data 16'hDEAD. req_done 5 cycles after accept, req_error=0.
- Read req_addr=22'h3FFFFF, controller returns 16'h5678 then 16'h1234 with 3-cycle waits → addresses 23'h7FFFFE and 23'h7FFFFF issued. req_data_read=32'h1234_5678 when req_done=1.
- SDRAM_ready low for 4 cycles in LO_ISSUE, plus a spurious SDRAM_done in IDLE → no SDRAM_as until ready. Spurious done ignored; req_ready unaffected.
- TIMEOUT_CYCLES=8, high-half SDRAM_done never returns → req_done=1, req_error=1, req_data_read=0 after 8 HI_WAIT cycles; then back in IDLE with req_ready=1.
- rst_l asserted during HI_WAIT, SDRAM_done arrives 1 cycle after release → no req_done; state IDLE; the next request completes normally.
